// File: rtl/rx_381bit.sv
`default_nettype none
// ============================================================================
// Module      : rx_381bit
// Description : UART 8N1 receiver that assembles NUM_BYTES bytes, LSB byte
//               first, into a 381-bit operand and flags completion.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_381bit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         RxD,
    output logic [380:0] RxData,
    output logic         done,
    output logic         frame_err
);

    localparam int          c_OP_W     = NUM_BYTES * 8;
    localparam logic [15:0] c_HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_FULL_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  c_LAST_IDX = 6'(NUM_BYTES - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_FULL  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [1:0]        r_sync;
    logic [15:0]       r_clk_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_byte;
    logic [5:0]        r_idx;
    logic [c_OP_W-1:0] r_data;
    logic              r_done;
    logic              r_ferr;

    logic w_rx;
    logic w_half_hit;
    logic w_bit_hit;
    logic w_start_go;
    logic w_shift;
    logic w_accept;
    logic w_ferr_set;
    logic w_cnt_run;

    assign w_rx       = r_sync[1];
    assign w_half_hit = (r_clk_cnt == c_HALF_M1);
    assign w_bit_hit  = (r_clk_cnt == c_FULL_M1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping enable aborts any frame in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (enable && !r_done && !w_rx) w_next = c_S_START;
            end
            c_S_START: begin
                if (!enable)         w_next = c_S_IDLE;
                else if (w_half_hit) w_next = w_rx ? c_S_IDLE : c_S_DATA;
            end
            c_S_DATA: begin
                if (!enable)                           w_next = c_S_IDLE;
                else if (w_bit_hit && r_bit_cnt == 3'd7) w_next = c_S_STOP;
            end
            c_S_STOP: begin
                if (!enable)        w_next = c_S_IDLE;
                else if (w_bit_hit) w_next = (w_rx && r_idx == c_LAST_IDX) ? c_S_FULL : c_S_IDLE;
            end
            c_S_FULL: begin
                if (!enable) w_next = c_S_IDLE;
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    // Output/strobe logic driving the datapath
    always_comb begin
        w_start_go = 1'b0;
        w_shift    = 1'b0;
        w_accept   = 1'b0;
        w_ferr_set = 1'b0;
        w_cnt_run  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_start_go = enable && !r_done && !w_rx;
            end
            c_S_START: begin
                w_cnt_run = enable && !w_half_hit;
            end
            c_S_DATA: begin
                w_shift   = enable && w_bit_hit;
                w_cnt_run = enable && !w_bit_hit;
            end
            c_S_STOP: begin
                w_accept   = enable && w_bit_hit && w_rx;
                w_ferr_set = enable && w_bit_hit && !w_rx;
                w_cnt_run  = enable && !w_bit_hit;
            end
            default: ;
        endcase
    end

    // Datapath: synchronizer, bit timing, byte shifter and operand store
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_byte    <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], RxD};
            r_ferr    <= w_ferr_set;
            r_clk_cnt <= w_cnt_run ? r_clk_cnt + 16'd1 : 16'd0;

            if (w_start_go) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift) begin
                r_byte <= {w_rx, r_byte[7:1]};
            end

            if (!enable) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 6'd1;
            end

            // The first byte of an operand wipes whatever the previous one left
            if (w_accept) begin
                if (r_idx == 6'd0) begin
                    r_data <= {{(c_OP_W-8){1'b0}}, r_byte};
                end else begin
                    r_data[{r_idx, 3'b000} +: 8] <= r_byte;
                end
            end

            if (!enable) begin
                r_done <= 1'b0;
            end else if (w_accept && r_idx == c_LAST_IDX) begin
                r_done <= 1'b1;
            end
        end
    end

    generate
        if (c_OP_W >= 381) begin : g_trunc
            logic w_unused_top;
            assign RxData       = r_data[380:0];
            assign w_unused_top = ^r_data[c_OP_W-1:380];
        end else begin : g_pad
            assign RxData = 381'(r_data);
        end
    endgenerate

    assign done      = r_done;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_rx_381bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_381bit
// Description : Directed self-checking bench for rx_381bit at 4 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_381bit;

    localparam int C  = 4;
    localparam int NB = 48;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         RxD;
    logic [380:0] RxData;
    logic         done;
    logic         frame_err;

    int n_pass   = 0;
    int n_total  = 0;
    int ferr_cnt = 0;

    logic [383:0] exp_wide;
    logic [7:0]   b;

    rx_381bit #(
        .CLKS_PER_BIT (C),
        .NUM_BYTES    (NB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .RxD       (RxD),
        .RxData    (RxData),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [380:0] got, input logic [380:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic send_bit(input logic v);
        RxD = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Frame followed by one idle bit so the stop sample has been taken on return
    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_frame(d, stop);
        send_bit(1'b1);
    endtask

    task automatic leave_full();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (C) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        RxD    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rxdata", RxData, '0);
        check("reset_done", 381'(done), 381'(0));
        check("reset_frame_err", 381'(frame_err), 381'(0));
        reset  = 1'b0;
        enable = 1'b1;
        repeat (C) @(negedge clk);

        // Full operand of 0xFF bytes
        for (int k = 0; k < NB - 1; k++) send_byte(8'hFF, 1'b1);
        check("ff_done_before_last", 381'(done), 381'(0));
        send_frame(8'hFF, 1'b1);
        check("ff_done_at_last_stop", 381'(done), 381'(0));
        send_bit(1'b1);
        check("ff_done_after_last", 381'(done), 381'(1));
        check("ff_rxdata", RxData, {381{1'b1}});
        check("ff_no_frame_err", 381'(ferr_cnt), 381'(0));

        // FULL ignores the line
        send_byte(8'h00, 1'b1);
        check("full_hold_rxdata", RxData, {381{1'b1}});
        check("full_hold_done", 381'(done), 381'(1));

        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disable_clears_done", 381'(done), 381'(0));
        check("disable_keeps_rxdata", RxData, {381{1'b1}});
        enable = 1'b1;
        repeat (C) @(negedge clk);

        // Byte order
        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        check("order_partial", RxData, 381'h8001);
        for (int k = 2; k < NB; k++) send_byte(8'h00, 1'b1);
        check("order_done", 381'(done), 381'(1));
        check("order_rxdata", RxData, 381'h8001);
        leave_full();

        // Framing error on byte 5, then resent
        for (int k = 0; k < 5; k++) send_byte(8'((k + 1) * 17), 1'b1);
        send_byte(8'h66, 1'b0);
        check("ferr_pulse_count", 381'(ferr_cnt), 381'(1));
        check("ferr_byte_discarded", RxData, 381'h5544332211);
        send_byte(8'h66, 1'b1);
        check("ferr_resent_byte5", RxData, 381'h665544332211);
        check("ferr_single_pulse", 381'(ferr_cnt), 381'(1));

        // One-cycle glitch in IDLE
        RxD = 1'b0;
        @(negedge clk);
        RxD = 1'b1;
        repeat (3 * C) @(negedge clk);
        send_byte(8'h77, 1'b1);
        check("glitch_no_byte", RxData, 381'h77665544332211);
        check("glitch_no_ferr", 381'(ferr_cnt), 381'(1));

        // Enable dropped mid-byte after 10 bytes
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        enable = 1'b0;
        RxD    = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("drop_keeps_rxdata", RxData, 381'hAA998877665544332211);
        check("drop_no_ferr", 381'(ferr_cnt), 381'(1));
        enable = 1'b1;
        repeat (C) @(negedge clk);

        exp_wide = '0;
        for (int k = 0; k < NB; k++) begin
            b = 8'(k * 7 + 3);
            exp_wide[k*8 +: 8] = b;
            send_byte(b, 1'b1);
            if (k == 0) check("reenable_byte0_clears", RxData, 381'h03);
        end
        check("reenable_done", 381'(done), 381'(1));
        check("reenable_rxdata", RxData, exp_wide[380:0]);
        leave_full();

        // Reset during byte 3
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        RxD   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_rxdata", RxData, '0);
        check("midreset_done", 381'(done), 381'(0));
        check("midreset_frame_err", 381'(frame_err), 381'(0));
        repeat (3 * C) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        check("post_reset_byte0", RxData, 381'h5A);
        check("post_reset_not_done", 381'(done), 381'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_381bit.md
RX_381BIT -- requirements
Module: rx_381bit

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter NUM_BYTES, default 48, bytes per operand (48 x 8 = 384 bits, which covers 381 bits).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1; high allows reception, low holds the block idle and clears progress.
REQ-006 SHALL have port RxD, input, 1, asynchronous UART line, idle high.
REQ-007 SHALL have port RxData, output, 381, the assembled operand.
REQ-008 SHALL have port done, output, 1, level high once a full operand has been received.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-010 SHALL pass RxD through a two-flop synchronizer, initialized high; all decoding uses the synchronized signal.
REQ-011 SHALL use UART 8N1 framing: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP, FULL.
REQ-013 SHALL move IDLE->START when enable=1, done=0 and the synchronized RxD is 0; the bit counter is cleared on entry.
REQ-014 SHALL, in START, re-sample at CLKS_PER_BIT/2 (integer division): a 0 goes to DATA, a 1 (glitch) returns to IDLE with no byte counted.
REQ-015 SHALL, in DATA, sample every CLKS_PER_BIT cycles after the START mid-sample, shifting 8 bits into a byte register LSB first, then go to STOP.
REQ-016 SHALL, in STOP, sample once at CLKS_PER_BIT after the last data sample:
- 1 -> write the byte, increment the byte index, return to IDLE.
- 0 -> discard the byte, pulse frame_err for 1 cycle, leave the byte index unchanged, return to IDLE.
REQ-017 SHALL write byte k (0-based arrival order) to operand bits [8k+7:8k]: byte 0 is least significant; bits 383:381 of byte 47 are dropped.
REQ-018 SHALL keep RxData bits that are not yet written in the current operand at 0; the operand register is cleared when byte 0 is accepted.
REQ-019 SHALL assert done in the cycle after byte NUM_BYTES-1 is accepted, and enter FULL.
REQ-020 SHALL, in FULL, hold done=1 and RxData stable and ignore RxD.
REQ-021 SHALL leave FULL only when enable=0; it then goes to IDLE with done=0 and byte index=0, and RxData is retained until the next byte 0.
REQ-022 SHALL, when enable falls mid-byte, abort to IDLE on the next cycle, discard the partial byte and clear the byte index; frame_err stays 0.
REQ-023 SHALL give reset priority over enable and RxD when both act in the same cycle.
REQ-024 SHALL keep the byte index 6 bits wide and the bit-timing counter 16 bits wide; no wrap occurs because FULL stops counting.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set: FSM=IDLE, RxData=0, done=0, frame_err=0, byte index=0, bit counter=0, timing counter=0, synchronizer=11.
REQ-026 SHALL apply reset mid-frame on the next edge, with no partial byte written.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-027 SHALL cover full operand: enable=1, send 48 bytes of 0xFF -> done rises 1 cycle after the 48th stop sample, and RxData = 381 bits all 1s.
REQ-028 SHALL cover byte order: send byte0=0x01, byte1=0x80, then 46 bytes of 0x00 -> RxData = 0x8001 (bit 0 and bit 15 set), done=1.
REQ-029 SHALL cover framing error: byte 5 with stop=0 -> frame_err pulses once, byte index stays 5, and a resent byte 5 lands at bits [47:40].
REQ-030 SHALL cover glitch rejection: a 1-cycle low on RxD in IDLE -> returns to IDLE, no byte counted, frame_err=0.
REQ-031 SHALL cover enable drop: deassert enable after 10 bytes, re-enable, send 48 bytes -> operand built from the new bytes only, done=1.
REQ-032 SHALL cover reset in DATA: assert reset for 1 cycle during byte 3 -> all outputs 0 the next cycle, and the following frame is received as byte 0.
